// File: rtl/soc_msp430_ram_pkg.sv
// Shared types and constants for the MSP430-style single-port RAM initiator.
//   state_t     : top-level FSM states (IDLE serves requests, INIT fills the RAM)
//   WEN_*       : low-active byte write-enable codes driven on ram_wen
//   SZ_*        : request size encoding on req_size
//   byte_lane() : extracts one byte of a RAM word into the low half of a response
package soc_msp430_ram_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  // Bit 1 gates the high byte and bit 0 the low byte, both low-active.
  localparam logic [1:0] WEN_WORD = 2'b00;
  localparam logic [1:0] WEN_HI   = 2'b01;
  localparam logic [1:0] WEN_LO   = 2'b10;
  localparam logic [1:0] WEN_NONE = 2'b11;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  function automatic logic [15:0] byte_lane(input logic [15:0] word, input logic hi);
    logic [15:0] res;
    if (hi) begin
      res = {8'h00, word[15:8]};
    end else begin
      res = {8'h00, word[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_msp430_ram_init_seq.sv
// Word counter for the RAM fill engine.
//   clk, rst : clock and asynchronous active-high reset
//   start    : begin a fill at word 0 (ignored while a fill is running)
//   busy     : a fill is in progress; addr is valid whenever busy is high
//   last     : the current word is the final one of the fill
//   addr     : word address being written this cycle
module soc_msp430_ram_init_seq
  import soc_msp430_ram_pkg::*;
#(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              last,
  output logic [ADDR_MSB:0] addr
);

  localparam int AW = ADDR_MSB + 1;
  localparam logic [ADDR_MSB:0] LAST_IDX = AW'(MEM_SIZE / 2 - 1);

  logic [ADDR_MSB:0] cnt_r;
  logic              busy_r;
  logic              last_s;

  assign last_s = busy_r & (cnt_r == LAST_IDX);

  // Counter and busy flag; the counter clears when the final word is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {AW{1'b0}};
      busy_r <= 1'b0;
    end else if (busy_r) begin
      if (last_s) begin
        cnt_r  <= {AW{1'b0}};
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + {{ADDR_MSB{1'b0}}, 1'b1};
        busy_r <= 1'b1;
      end
    end else if (start) begin
      cnt_r  <= {AW{1'b0}};
      busy_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

  assign busy = busy_r;
  assign last = last_s;
  assign addr = cnt_r;

endmodule

// File: rtl/soc_msp430_ram_master.sv
// Initiator side of a single-port RAM: converts a byte-addressed valid/ready
// request stream into RAM cycles and returns one-cycle response pulses, and
// can fill the whole RAM with INIT_VAL.
//   mclk, puc_rst        : clock and asynchronous active-high reset
//   req_valid/req_ready  : request handshake (accepted when both high)
//   req_addr/we/size/wdata : byte address, write flag, size (0 byte, 1 word), data
//   rsp_valid/rdata/err  : response pulse one cycle after accept
//   init_start/init_busy : start a RAM fill / fill in progress
//   ram_addr/cen/wen/din : RAM controls (cen and wen low-active)
//   ram_dout             : RAM read data, one cycle after the access
module soc_msp430_ram_master
  import soc_msp430_ram_pkg::*;
#(
  parameter int          ADDR_MSB = 6,
  parameter int          MEM_SIZE = 256,
  parameter logic [15:0] INIT_VAL = 16'h0000
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_MSB+1:0] req_addr,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              init_start,
  output logic              init_busy,
  output logic [ADDR_MSB:0] ram_addr,
  output logic              ram_cen,
  output logic [1:0]        ram_wen,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam int          AW    = ADDR_MSB + 1;
  localparam int unsigned WORDS = MEM_SIZE / 2;

  state_t            state_r;
  state_t            state_nx_s;
  logic              init_go_s;
  logic              init_busy_s;
  logic              init_last_s;
  logic [ADDR_MSB:0] init_addr_s;

  logic [ADDR_MSB:0] word_idx_s;
  logic              odd_s;
  logic              ready_s;
  logic              accept_s;
  logic              err_s;

  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              rsp_rd_r;
  logic              rsp_byte_r;
  logic              rsp_hi_r;

  // ---------------------------------------------------------------- FSM
  assign init_go_s = (state_r == ST_IDLE) & init_start;

  // State register.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: a fill always runs to its last word once started.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init_start) begin
          state_nx_s = ST_INIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (init_last_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_INIT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  soc_msp430_ram_init_seq #(
    .ADDR_MSB (ADDR_MSB),
    .MEM_SIZE (MEM_SIZE)
  ) u_init_seq (
    .clk   (mclk),
    .rst   (puc_rst),
    .start (init_go_s),
    .busy  (init_busy_s),
    .last  (init_last_s),
    .addr  (init_addr_s)
  );

  assign init_busy = init_busy_s;

  // ------------------------------------------------------ request decode
  // init_start takes priority over a request presented in the same cycle.
  assign ready_s    = (state_r == ST_IDLE) & ~init_start;
  assign req_ready  = ready_s;
  assign accept_s   = req_valid & ready_s;
  assign word_idx_s = req_addr[ADDR_MSB+1:1];
  assign odd_s      = req_addr[0];
  assign err_s      = ((req_size == SZ_WORD) & odd_s) | (32'(word_idx_s) >= WORDS);

  // RAM control mux: fill write, accepted request, or quiet bus.
  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = WEN_NONE;
    ram_addr = {AW{1'b0}};
    ram_din  = 16'h0000;
    if (state_r == ST_INIT) begin
      ram_cen  = 1'b0;
      ram_wen  = WEN_WORD;
      ram_addr = init_addr_s;
      ram_din  = INIT_VAL;
    end else if (accept_s & ~err_s) begin
      ram_cen  = 1'b0;
      ram_addr = word_idx_s;
      if (req_we) begin
        if (req_size == SZ_WORD) begin
          ram_wen = WEN_WORD;
          ram_din = req_wdata;
        end else begin
          // Byte data is replicated on both lanes; wen picks the lane.
          ram_din = {req_wdata[7:0], req_wdata[7:0]};
          if (odd_s) begin
            ram_wen = WEN_HI;
          end else begin
            ram_wen = WEN_LO;
          end
        end
      end else begin
        ram_wen = WEN_NONE;
        ram_din = 16'h0000;
      end
    end else begin
      ram_cen  = 1'b1;
      ram_wen  = WEN_NONE;
      ram_addr = {AW{1'b0}};
      ram_din  = 16'h0000;
    end
  end

  // ------------------------------------------------------------ response
  // Response qualifiers captured at accept; ram_dout arrives in the next cycle.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rd_r    <= 1'b0;
      rsp_byte_r  <= 1'b0;
      rsp_hi_r    <= 1'b0;
    end else begin
      rsp_valid_r <= accept_s;
      rsp_err_r   <= accept_s & err_s;
      rsp_rd_r    <= accept_s & ~err_s & ~req_we;
      rsp_byte_r  <= (req_size == SZ_BYTE);
      rsp_hi_r    <= odd_s;
    end
  end

  // Read data is formed from the RAM output only for successful reads.
  always_comb begin
    rsp_rdata = 16'h0000;
    if (rsp_valid_r & rsp_rd_r) begin
      if (rsp_byte_r) begin
        rsp_rdata = byte_lane(ram_dout, rsp_hi_r);
      end else begin
        rsp_rdata = ram_dout;
      end
    end else begin
      rsp_rdata = 16'h0000;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;

endmodule
